// File: rtl/dial_cmd_sequencer.sv
// Parses an ASCII stream of L<n>/R<n> rotation commands and issues each one
// as a single-cycle pulse to the dial datapath; reports count, completion and errors.
module dial_cmd_sequencer #(
    parameter int MAX_DIGITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        dial_valid,
    output logic        dial_direction,
    output logic [31:0] dial_distance,
    output logic [31:0] cmd_count,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NUM   = 3'd1,
        ISSUE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] digit_cnt_q, digit_cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          dir_q, dir_d;
    logic          last_q, last_d;
    logic          accept;
    logic          is_ws, is_digit, is_lr;
    logic [35:0]   acc_next;

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready never depends on byte_valid, and byte_data/byte_last are only
    // looked at on that transfer.
    assign byte_ready = !clear && (state_q == IDLE || state_q == NUM);
    assign accept     = byte_valid && byte_ready;

    assign is_ws    = (byte_data == 8'h20) || (byte_data == 8'h0D) || (byte_data == 8'h0A);
    assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    assign is_lr    = (byte_data == 8'h4C) || (byte_data == 8'h52);
    // Upper bits of acc_next catch overflow past 32 bits.
    assign acc_next = ({4'd0, acc_q} * 36'd10) + {32'd0, byte_data[3:0]};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        digit_cnt_d = digit_cnt_q;
        dir_d       = dir_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_lr) begin
                        dir_d       = (byte_data == 8'h52);
                        acc_d       = '0;
                        digit_cnt_d = '0;
                        last_d      = 1'b0;
                        state_d     = byte_last ? ERR : NUM;
                    end else if (is_ws) begin
                        if (byte_last) state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            NUM: begin
                if (accept) begin
                    if (is_digit) begin
                        if (acc_next[35:32] != 4'd0 || digit_cnt_q == CW'(MAX_DIGITS)) begin
                            state_d = ERR;
                        end else begin
                            acc_d       = acc_next[31:0];
                            digit_cnt_d = digit_cnt_q + CW'(1);
                            if (byte_last) begin
                                last_d  = 1'b1;
                                state_d = ISSUE;
                            end
                        end
                    end else if (is_ws) begin
                        if (digit_cnt_q == '0) begin
                            state_d = ERR;
                        end else begin
                            last_d  = byte_last;
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ISSUE:   state_d = last_q ? DONE : IDLE;
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            digit_cnt_d = '0;
            last_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            digit_cnt_q    <= '0;
            dir_q          <= 1'b0;
            last_q         <= 1'b0;
            dial_direction <= 1'b0;
            dial_distance  <= '0;
            cmd_count      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            digit_cnt_q <= digit_cnt_d;
            dir_q       <= dir_d;
            last_q      <= last_d;
            // Command outputs are captured on entry to ISSUE and held afterwards.
            if (state_q == NUM && state_d == ISSUE) begin
                dial_direction <= dir_q;
                dial_distance  <= acc_d;
            end
            if (clear)
                cmd_count <= '0;
            else if (state_q == ISSUE)
                cmd_count <= cmd_count + 32'd1;
        end
    end

    assign dial_valid = (state_q == ISSUE) && !clear;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_dial_cmd_sequencer.sv
// Bench for dial_cmd_sequencer: directed and random ASCII streams checked
// against a string-level parser model and an expected-pulse queue.
module tb_dial_cmd_sequencer;

    localparam int MAX_DIGITS = 10;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        dial_valid;
    logic        dial_direction;
    logic [31:0] dial_distance;
    logic [31:0] cmd_count;
    logic        done;
    logic        error;

    dial_cmd_sequencer #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_last      (byte_last),
        .byte_ready     (byte_ready),
        .dial_valid     (dial_valid),
        .dial_direction (dial_direction),
        .dial_distance  (dial_distance),
        .cmd_count      (cmd_count),
        .done           (done),
        .error          (error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = -10;
    bit ready_chk = 1'b0;

    logic [32:0] exp_q[$];
    int          pulse_cyc[$];
    logic [32:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // string-level reference parser: pushes expected {dir, dist} pulses
    function automatic void ref_model(input string s, input bit last_on_end,
                                      output bit m_done, output bit m_err, output int n);
        bit     in_num;
        bit     dir;
        longint v;
        int     nd;
        byte    c;
        bit     last, ws, dig;
        in_num = 0; dir = 0; v = 0; nd = 0;
        m_done = 0; m_err = 0; n = 0;
        for (int i = 0; i < s.len(); i++) begin
            c    = s[i];
            last = last_on_end && (i == s.len() - 1);
            ws   = (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A);
            dig  = (c >= 8'h30) && (c <= 8'h39);
            if (!in_num) begin
                if (c == 8'h4C || c == 8'h52) begin
                    if (last) m_err = 1;
                    else begin dir = (c == 8'h52); v = 0; nd = 0; in_num = 1; end
                end else if (ws) begin
                    if (last) m_done = 1;
                end else begin
                    m_err = 1;
                end
            end else begin
                if (dig) begin
                    nd++;
                    v = v * 10 + longint'(c - 8'h30);
                    if (nd > MAX_DIGITS || v > 64'hFFFF_FFFF) m_err = 1;
                    else if (last) begin
                        exp_q.push_back({dir, v[31:0]}); n++; m_done = 1;
                    end
                end else if (ws) begin
                    if (nd == 0) m_err = 1;
                    else begin
                        exp_q.push_back({dir, v[31:0]}); n++; in_num = 0;
                        if (last) m_done = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (m_err || m_done) break;
        end
    endfunction

    // pulse scoreboard and timing monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (dial_valid) begin
                check("pulse_latency", 64'(cyc), 64'(last_acc_cyc + 1));
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_pulse", {63'd0, dial_valid}, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_dir", {63'd0, dial_direction}, {63'd0, e[32]});
                    check("pulse_dist", {32'd0, dial_distance}, {32'd0, e[31:0]});
                end
            end
            if (ready_chk) check("ready_vs_issue", {63'd0, byte_ready}, {63'd0, !dial_valid});
            if (byte_valid && byte_ready) last_acc_cyc = cyc;
        end
    end

    // driver tasks: all entered and left at posedge + #1
    task automatic drive_stream(input string s, input bit last_on_end, input bit gaps);
        bit acc;
        int w;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            byte_valid = 1'b1;
            byte_data  = s[i];
            byte_last  = last_on_end && (i == s.len() - 1);
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 10) begin
                @(negedge clk);
                acc = byte_ready;
                w++;
                if (!acc) @(posedge clk);
            end
            @(posedge clk);
            #1;
            if (!acc) break;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        pulse_cyc.delete();
    endtask

    task automatic finish_checks(input bit md, input bit me, input int n);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_pulses", 64'(exp_q.size()), 64'd0);
        check("done", {63'd0, done}, {63'd0, md});
        check("error", {63'd0, error}, {63'd0, me});
        check("cmd_count", {32'd0, cmd_count}, 64'(n));
        check("ready_after", {63'd0, byte_ready}, {63'd0, !(md || me)});
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input string s, input bit gaps);
        bit md, me;
        int n;
        do_clear();
        ref_model(s, 1'b1, md, me, n);
        drive_stream(s, 1'b1, gaps);
        finish_checks(md, me, n);
    endtask

    function automatic string gen_stream();
        string  s;
        string  ws;
        longint v;
        int     ncmd;
        s    = "";
        ncmd = $urandom_range(1, 6);
        for (int k = 0; k < ncmd; k++) begin
            if ($urandom_range(0, 3) == 0) s = {s, " "};
            s = {s, ($urandom_range(0, 1) == 1) ? "R" : "L"};
            case ($urandom_range(0, 9))
                7:       v = longint'($urandom);
                8:       v = 64'd4294967295 + longint'($urandom_range(0, 1));
                default: v = longint'($urandom_range(0, 9999));
            endcase
            if ($urandom_range(0, 9) == 0) s = {s, "0"};
            s = {s, $sformatf("%0d", v)};
            if ($urandom_range(0, 24) == 0) s = {s, ($urandom_range(0, 1) == 1) ? "a" : "r"};
            case ($urandom_range(0, 2))
                0:       ws = " ";
                1:       ws = "\n";
                default: ws = "\r\n";
            endcase
            if (!(k == ncmd - 1 && $urandom_range(0, 2) == 0)) s = {s, ws};
        end
        return s;
    endfunction

    initial begin
        bit md, me;
        int n;
        rst_n      = 1'b0;
        clear      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'd0, byte_ready}, 64'd1);
        check("rst_valid", {63'd0, dial_valid}, 64'd0);
        check("rst_dir", {63'd0, dial_direction}, 64'd0);
        check("rst_dist", {32'd0, dial_distance}, 64'd0);
        check("rst_count", {32'd0, cmd_count}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_stream("L68\nR48\n", 1'b0);
        run_stream("R5", 1'b0);
        run_stream(" \n", 1'b1);
        do_clear();
        @(negedge clk);
        check("clear_done", {63'd0, done}, 64'd0);
        check("clear_ready", {63'd0, byte_ready}, 64'd1);
        @(posedge clk);
        #1;
        run_stream("R4294967295\n", 1'b0);
        run_stream("R0\n", 1'b1);
        run_stream("R4294967296\n", 1'b0);
        run_stream("R00000000001\n", 1'b0);
        run_stream("R0000000001\n", 1'b0);
        run_stream("L\n", 1'b0);
        run_stream("X5\n", 1'b0);
        run_stream("R1a\n", 1'b0);
        run_stream("r7\n", 1'b0);
        do_clear();
        @(negedge clk);
        check("clear_error", {63'd0, error}, 64'd0);
        check("clear_count", {32'd0, cmd_count}, 64'd0);
        @(posedge clk);
        #1;

        // continuous valid: ready drops only in ISSUE, pulses 4 cycles apart
        do_clear();
        ref_model("R1\nL2\n", 1'b1, md, me, n);
        ready_chk = 1'b1;
        drive_stream("R1\nL2\n", 1'b1, 1'b0);
        ready_chk = 1'b0;
        finish_checks(md, me, n);
        check("pulse_pair", 64'(pulse_cyc.size()), 64'd2);
        if (pulse_cyc.size() == 2)
            check("pulse_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd4);

        // clear mid-number discards the partial command
        do_clear();
        drive_stream("R12", 1'b0, 1'b0);
        do_clear();
        ref_model("L3\n", 1'b1, md, me, n);
        drive_stream("L3\n", 1'b1, 1'b0);
        finish_checks(md, me, n);

        // asynchronous reset mid-stream
        do_clear();
        ref_model("L5\nR12", 1'b0, md, me, n);
        drive_stream("L5\nR12", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_count", {32'd0, cmd_count}, 64'(n));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", {32'd0, cmd_count}, 64'd0);
        check("async_rst_valid", {63'd0, dial_valid}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_stream("L3\n", 1'b0);

        for (int t = 0; t < 40; t++) run_stream(gen_stream(), ($urandom_range(0, 1) == 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
